// File: rtl/ram_fmint_pp.sv
// rtl/ram_fmint_pp.sv - two-bank ping-pong tile RAM with done/ready ownership handoff
module ram_fmint_pp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    output logic              wr_bank,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic              rd_bank,
    output logic [1:0]        n_full,
    output logic              err
);
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [1:0]        state_q, state_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;

    logic wr_addr_ok, rd_addr_ok;
    logic wr_acc, rd_acc, fill, drain, bad;

    assign wr_ready   = ~state_q[wptr_q];
    assign rd_ready   = state_q[rptr_q];
    assign wr_bank    = wptr_q;
    assign rd_bank    = rptr_q;
    assign n_full     = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign err        = err_q;

    assign wr_addr_ok = {1'b0, wr_addr} < DEPTH_C;
    assign rd_addr_ok = {1'b0, rd_addr} < DEPTH_C;
    assign wr_acc     = wr_en & wr_ready & wr_addr_ok;
    assign rd_acc     = rd_en & rd_ready & rd_addr_ok;
    assign fill       = wr_done & wr_ready;
    assign drain      = rd_done & rd_ready;
    assign bad        = (wr_en & ~wr_ready) | (wr_done & ~wr_ready)
                      | (rd_en & ~rd_ready) | (rd_done & ~rd_ready)
                      | (wr_en & ~wr_addr_ok) | (rd_en & ~rd_addr_ok);

    // fill and drain can only coincide on different banks (one EMPTY, one FULL).
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        if (fill) begin
            state_d[wptr_q] = 1'b1;
            wptr_d          = ~wptr_q;
        end
        if (drain) begin
            state_d[rptr_q] = 1'b0;
            rptr_d          = ~rptr_q;
        end
        if (rd_acc) begin
            rd_data_d  = mem_q[rptr_q][rd_addr];
            rd_valid_d = 1'b1;
        end
        if (bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= 2'b00;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage is not reset; a write coinciding with wr_done lands in the bank being closed.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wptr_q][wr_addr] <= wr_data;
        end
    end
endmodule

// File: doc/ram_fmint_pp.md
Name: ram_fmint_pp

Overview:
Parametrised ping-pong successor of the intermediate-FM tile RAM. It holds two banks of DEPTH words. The producer (expansion conv stage) fills one bank while the consumer (depthwise stage) drains the other. Tile ownership passes between the two sides through a done/ready handshake per port, so fill and drain of consecutive tiles overlap without stalls.

Parameters:
DATA_W, PX_W, width of one stored element
DEPTH, FMINT_N_ELEM, words per bank (any value >= 2, not necessarily a power of two)
AW, $clog2(DEPTH), address width (derived; not to be overridden)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
wr_en  in  1  write request into current write bank
wr_addr  in  AW  write address within bank
wr_data  in  DATA_W  write data
wr_done  in  1  producer finished current tile; hand bank to reader
wr_ready  out  1  current write bank is EMPTY (writes accepted)
wr_bank  out  1  index of current write bank
rd_en  in  1  read request from current read bank
rd_addr  in  AW  read address within bank
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data valid (1 cycle after accepted rd_en)
rd_done  in  1  consumer finished tile; release bank
rd_ready  out  1  current read bank is FULL (reads accepted)
rd_bank  out  1  index of current read bank
n_full  out  2  number of FULL banks (0..2)
err  out  1  sticky protocol error flag

Behaviour:
- Storage: 2 x DEPTH x DATA_W array. Contents are not reset. No read-to-write forwarding is needed, because the two ports never address the same bank while it is legal to do so.
- Per-bank state, 1 bit each: EMPTY or FULL. Two registered pointers, wptr and rptr. wr_bank = wptr, rd_bank = rptr.
- wr_ready = state[wptr]==EMPTY. rd_ready = state[rptr]==FULL. Both are combinational from registers.
- n_full = popcount(state).
- Write: when wr_en & wr_ready & wr_addr<DEPTH, mem[wptr][wr_addr] <= wr_data.
- Fill: when wr_done & wr_ready, state[wptr] <= FULL and wptr <= ~wptr.
- A write in the same cycle as wr_done lands in the bank being closed.
- Read: when rd_en & rd_ready & rd_addr<DEPTH, rd_data <= mem[rptr][rd_addr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value. Latency is exactly 1 cycle.
- Drain: when rd_done & rd_ready, state[rptr] <= EMPTY and rptr <= ~rptr.
- A read in the same cycle as rd_done uses the bank being released. Its data still appears next cycle with rd_valid=1.
- Simultaneous wr_done and rd_done: both take effect in the same cycle. They always target different banks.
  - Example: n_full=1, wptr!=rptr → n_full stays 1, both pointers toggle.
- Fill-to-read turnaround: a bank closed by wr_done at cycle t has rd_ready=1 at t+1 if rptr points at it.
- Errors set err <= 1, which holds until rst. Each offending request is ignored with no state or memory change:
  - wr_en with !wr_ready
  - wr_done with !wr_ready
  - rd_en with !rd_ready
  - rd_done with !rd_ready
  - wr_addr>=DEPTH while wr_en
  - rd_addr>=DEPTH while rd_en
- Reset, synchronous:
  - state = {EMPTY, EMPTY}, wptr = 0, rptr = 0
  - rd_data = 0, rd_valid = 0, err = 0
  - Gives wr_ready=1, rd_ready=0, n_full=0.
- Reset mid-operation: rst dominates all inputs in that cycle. Any in-flight read is dropped, so rd_valid=0 the cycle after rst. Memory contents are preserved but are logically discarded because both banks are EMPTY.
- Full: n_full=2 → wr_ready=0; the producer must wait for rd_done.
- Empty: n_full=0 → rd_ready=0.

Test Plan:
1. Reset → wr_ready=1, rd_ready=0, n_full=0, rd_valid=0, err=0, wr_bank=0, rd_bank=0.
2. DEPTH=16, DATA_W=16. Write addr i = 0x100+i for i=0..15, then wr_done.
   - Next cycle: rd_ready=1, wr_bank=1, n_full=1.
   - Read addr 5 → rd_data=0x105 with rd_valid=1 exactly 1 cycle later.
3. Overlap:
   - While draining bank0, fill bank1 with 0x200+i.
   - Assert wr_done and rd_done in the same cycle → n_full stays 1, rd_bank=1, wr_bank=0.
   - Read addr 3 → 0x203.
4. Full: fill both banks (n_full=2, wr_ready=0), then wr_en addr 0 data 0xDEAD.
   - Required: err=1.
   - Later reads of bank0 addr 0 return the original value (0x100).
5. Boundary:
   - rd_en with addr 15 → valid data.
   - rd_en with addr 16 (AW=4 cannot express this; use DEPTH=12 with addr 12) → rd_valid=0, err=1.
   - rd_en when n_full=0 → rd_valid=0, err=1.
6. rst asserted in the same cycle as rd_en, with n_full=2 → next cycle rd_valid=0, n_full=0, wr_ready=1, err=0.
